// File: rtl/md_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: md_op codes, FSM states
// and the 32x32->64 multiply helper used by md_unit.
package md_pkg;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MTHI  = 4'd5,
      MD_MTLO  = 4'd6,
      MD_MADD  = 4'd7,
      MD_MADDU = 4'd8,
      MD_MSUB  = 4'd9,
      MD_MSUBU = 4'd10
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

   localparam logic [31:0] MD_ALL_ONES = 32'hFFFF_FFFF;
   localparam logic [31:0] MD_MIN_INT  = 32'h8000_0000;

   // Sign- or zero-extend both operands to 64 bits; the low 64 bits of the
   // product are then the correct two's-complement or unsigned result.
   function automatic logic [63:0] md_mul64(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic        is_signed);
      logic [63:0] ext_a;
      logic [63:0] ext_b;
      ext_a = is_signed ? {{32{a[31]}}, a} : {32'b0, a};
      ext_b = is_signed ? {{32{b[31]}}, b} : {32'b0, b};
      return ext_a * ext_b;
   endfunction

endpackage

// File: rtl/md_divider.sv
// Combinational 32-bit signed/unsigned divider with MIPS-style results for
// divide-by-zero (lo=all ones, hi=dividend) and the INT_MIN / -1 overflow.
module md_divider
   import md_pkg::*;
(
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   input  logic        is_signed,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   logic        div_zero;
   logic        overflow;
   logic [31:0] uq;
   logic [31:0] ur;
   logic [31:0] sq;
   logic [31:0] sr;

   assign div_zero = (divisor == 32'd0);
   assign overflow = is_signed && (dividend == MD_MIN_INT) && (divisor == MD_ALL_ONES);

   // Raw quotients are only evaluated when the divisor is legal, so the
   // operators never see a zero divisor or the overflowing signed case.
   always_comb begin
      uq = 32'd0;
      ur = 32'd0;
      sq = 32'd0;
      sr = 32'd0;
      if (!div_zero) begin
         uq = dividend / divisor;
         ur = dividend % divisor;
         if (!overflow) begin
            sq = $signed(dividend) / $signed(divisor);
            sr = $signed(dividend) % $signed(divisor);
         end
      end
   end

   always_comb begin
      quotient  = 32'd0;
      remainder = 32'd0;
      if (div_zero) begin
         quotient  = MD_ALL_ONES;
         remainder = dividend;
      end else if (overflow) begin
         quotient  = MD_MIN_INT;
         remainder = 32'd0;
      end else if (is_signed) begin
         quotient  = sq;
         remainder = sr;
      end else begin
         quotient  = uq;
         remainder = ur;
      end
   end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit owning HI/LO; results appear after a fixed busy
// latency. Define MD_MADD_EN to enable MADD/MADDU/MSUB/MSUBU accumulation.
module md_unit
   import md_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  md_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   md_state_e        state;
   md_state_e        state_next;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic [31:0]      ph;
   logic [31:0]      pl;
   logic [31:0]      ph_next;
   logic [31:0]      pl_next;
   logic [31:0]      hi_next;
   logic [31:0]      lo_next;

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        div_signed;
   logic [31:0] div_q;
   logic [31:0] div_r;

   assign prod_s     = md_mul64(src_a, src_b, 1'b1);
   assign prod_u     = md_mul64(src_a, src_b, 1'b0);
   assign div_signed = (md_op == MD_DIV);

   md_divider u_divider (
      .dividend  (src_a),
      .divisor   (src_b),
      .is_signed (div_signed),
      .quotient  (div_q),
      .remainder (div_r)
   );

`ifdef MD_MADD_EN
   logic [63:0] acc;
   assign acc = {hi, lo};
`endif

   // The full result is computed in the start cycle and parked in {ph,pl};
   // the counter only models latency, HI/LO are written on the final busy edge.
   always_comb begin
      state_next = state;
      count_next = count;
      ph_next    = ph;
      pl_next    = pl;
      hi_next    = hi;
      lo_next    = lo;
      case (state)
         ST_IDLE: begin
            if (start) begin
               case (md_op)
                  MD_MULT: begin
                     {ph_next, pl_next} = prod_s;
                     count_next         = CNT_W'(MULT_CYCLES);
                     state_next         = ST_BUSY;
                  end
                  MD_MULTU: begin
                     {ph_next, pl_next} = prod_u;
                     count_next         = CNT_W'(MULT_CYCLES);
                     state_next         = ST_BUSY;
                  end
                  MD_DIV, MD_DIVU: begin
                     ph_next    = div_r;
                     pl_next    = div_q;
                     count_next = CNT_W'(DIV_CYCLES);
                     state_next = ST_BUSY;
                  end
                  MD_MTHI: hi_next = src_a;
                  MD_MTLO: lo_next = src_a;
`ifdef MD_MADD_EN
                  MD_MADD: begin
                     {ph_next, pl_next} = acc + prod_s;
                     count_next         = CNT_W'(MULT_CYCLES);
                     state_next         = ST_BUSY;
                  end
                  MD_MADDU: begin
                     {ph_next, pl_next} = acc + prod_u;
                     count_next         = CNT_W'(MULT_CYCLES);
                     state_next         = ST_BUSY;
                  end
                  MD_MSUB: begin
                     {ph_next, pl_next} = acc - prod_s;
                     count_next         = CNT_W'(MULT_CYCLES);
                     state_next         = ST_BUSY;
                  end
                  MD_MSUBU: begin
                     {ph_next, pl_next} = acc - prod_u;
                     count_next         = CNT_W'(MULT_CYCLES);
                     state_next         = ST_BUSY;
                  end
`endif
                  default: begin
                  end
               endcase
            end
         end
         ST_BUSY: begin
            count_next = count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
               hi_next    = ph;
               lo_next    = pl;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         count <= '0;
         ph    <= 32'd0;
         pl    <= 32'd0;
         hi    <= 32'd0;
         lo    <= 32'd0;
      end else begin
         state <= state_next;
         count <= count_next;
         ph    <= ph_next;
         pl    <= pl_next;
         hi    <= hi_next;
         lo    <= lo_next;
      end
   end

   assign busy = (state == ST_BUSY);

   // The hazard unit must stall any md instruction while an operation is in flight.
   start_while_busy: assert property (@(posedge clk) disable iff (reset) !(start && state == ST_BUSY));

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases with literal results plus
// randomized operations checked every cycle against a behavioural HI/LO model.
module tb_md_unit;
   import md_pkg::*;

   localparam int MULT_CYCLES = 5;
   localparam int DIV_CYCLES  = 10;

   logic        clk    = 1'b0;
   logic        reset  = 1'b0;
   logic        start  = 1'b0;
   logic [3:0]  md_op  = 4'd0;
   logic [31:0] src_a  = 32'd0;
   logic [31:0] src_b  = 32'd0;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int tests    = 0;
   int failures = 0;
   bit check_on = 1'b0;

   // Behavioural model: architectural HI/LO, the result waiting to land and
   // how many busy cycles remain before it does.
   logic [31:0] m_hi   = 32'd0;
   logic [31:0] m_lo   = 32'd0;
   logic [63:0] m_pend = 64'd0;
   int          m_left = 0;

   md_unit #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .md_op (md_op),
      .src_a (src_a),
      .src_b (src_b),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] md_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
      longint          sa;
      longint          sb;
      longint unsigned ua;
      longint unsigned ub;
      longint          q;
      longint          r;
      sa = $signed(a);
      sb = $signed(b);
      ua = a;
      ub = b;
      case (op)
         MD_MULT:  return sa * sb;
         MD_MULTU: return ua * ub;
         MD_DIV: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         MD_DIVU: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {32'(ua % ub), 32'(ua / ub)};
         end
         MD_MADD:  return acc + 64'(sa * sb);
         MD_MADDU: return acc + 64'(ua * ub);
         MD_MSUB:  return acc - 64'(sa * sb);
         MD_MSUBU: return acc - 64'(ua * ub);
         default:  return 64'd0;
      endcase
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_hi   = 32'd0;
         m_lo   = 32'd0;
         m_pend = 64'd0;
         m_left = 0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0) {m_hi, m_lo} = m_pend;
      end else if (start) begin
         case (md_op)
            MD_MTHI: m_hi = src_a;
            MD_MTLO: m_lo = src_a;
            MD_MULT, MD_MULTU: begin
               m_pend = md_result(md_op, src_a, src_b, {m_hi, m_lo});
               m_left = MULT_CYCLES;
            end
            MD_DIV, MD_DIVU: begin
               m_pend = md_result(md_op, src_a, src_b, {m_hi, m_lo});
               m_left = DIV_CYCLES;
            end
`ifdef MD_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: begin
               m_pend = md_result(md_op, src_a, src_b, {m_hi, m_lo});
               m_left = MULT_CYCLES;
            end
`endif
            default: begin
            end
         endcase
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_on) begin
         checkOutput("busy", {31'd0, busy}, (m_left > 0) ? 32'd1 : 32'd0);
         checkOutput("hi", hi, m_hi);
         checkOutput("lo", lo, m_lo);
      end
   end

   task automatic finishBench();
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   endtask

   // Inputs change 1 time unit after the rising edge; returns just after the start edge.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      md_op = op;
      src_a = a;
      src_b = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      md_op = MD_NONE;
   endtask

   task automatic waitIdle(output int busy_cycles);
      int waited;
      waited      = 0;
      busy_cycles = 0;
      while ((busy !== 1'b0 || m_left != 0) && waited < 100) begin
         if (busy === 1'b1) busy_cycles++;
         waited++;
         @(posedge clk);
         #1;
      end
      if (waited >= 100) begin
         tests++;
         failures++;
         $display("[TB] FAIL wait_idle: busy=%b after %0d cycles, expected 0", busy, waited);
         finishBench();
      end
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      int cyc;
      #2 reset = 1'b1;
      #1 check_on = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_hi", hi, 32'd0);
      checkOutput("reset_lo", lo, 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      applyStimulus(MD_MULT, 32'hFFFF_FFFF, 32'd2);
      waitIdle(cyc);
      checkOutput("mult_cycles", cyc, 32'd5);
      checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
      checkOutput("mult_lo", lo, 32'hFFFF_FFFE);

      applyStimulus(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
      waitIdle(cyc);
      checkOutput("multu_hi", hi, 32'h0000_0001);
      checkOutput("multu_lo", lo, 32'hFFFF_FFFE);

      applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'd2);
      waitIdle(cyc);
      checkOutput("div_cycles", cyc, 32'd10);
      checkOutput("div_lo", lo, 32'hFFFF_FFFD);
      checkOutput("div_hi", hi, 32'hFFFF_FFFF);

      applyStimulus(MD_DIVU, 32'd7, 32'd2);
      waitIdle(cyc);
      checkOutput("divu_lo", lo, 32'd3);
      checkOutput("divu_hi", hi, 32'd1);

      applyStimulus(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      waitIdle(cyc);
      checkOutput("div_ovf_lo", lo, 32'h8000_0000);
      checkOutput("div_ovf_hi", hi, 32'd0);

      applyStimulus(MD_DIVU, 32'h0000_1234, 32'd0);
      waitIdle(cyc);
      checkOutput("divz_lo", lo, 32'hFFFF_FFFF);
      checkOutput("divz_hi", hi, 32'h0000_1234);

      applyStimulus(MD_MTHI, 32'hDEAD_BEEF, 32'd0);
      checkOutput("mthi_busy", {31'd0, busy}, 32'd0);
      checkOutput("mthi_hi", hi, 32'hDEAD_BEEF);
      checkOutput("mthi_lo_kept", lo, 32'hFFFF_FFFF);
      applyStimulus(MD_MTLO, 32'h00C0_FFEE, 32'd0);
      checkOutput("mtlo_busy", {31'd0, busy}, 32'd0);
      checkOutput("mtlo_lo", lo, 32'h00C0_FFEE);
      checkOutput("mtlo_hi_kept", hi, 32'hDEAD_BEEF);

      applyStimulus(MD_MTHI, 32'd0, 32'd0);
      applyStimulus(MD_MTLO, 32'hFFFF_FFFF, 32'd0);
      applyStimulus(MD_MADDU, 32'd1, 32'd1);
      waitIdle(cyc);
`ifdef MD_MADD_EN
      checkOutput("maddu_cycles", cyc, 32'd5);
      checkOutput("maddu_hi", hi, 32'd1);
      checkOutput("maddu_lo", lo, 32'd0);
`else
      checkOutput("maddu_off_cycles", cyc, 32'd0);
      checkOutput("maddu_off_hi", hi, 32'd0);
      checkOutput("maddu_off_lo", lo, 32'hFFFF_FFFF);
`endif

      for (int i = 0; i < 300; i++) begin
         applyStimulus(4'($urandom_range(0, 15)), pickOperand(), pickOperand());
         waitIdle(cyc);
      end

      // Abort a divide partway through: reset must clear everything at once.
      applyStimulus(MD_MTHI, 32'h1111_2222, 32'd0);
      applyStimulus(MD_MTLO, 32'h3333_4444, 32'd0);
      applyStimulus(MD_DIV, 32'd100, 32'd3);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      checkOutput("pre_reset_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
      checkOutput("midreset_hi", hi, 32'd0);
      checkOutput("midreset_lo", lo, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      applyStimulus(MD_MULT, 32'd3, 32'd4);
      waitIdle(cyc);
      checkOutput("post_reset_lo", lo, 32'd12);
      checkOutput("post_reset_hi", hi, 32'd0);

      @(posedge clk);
      #1;
      finishBench();
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the five-stage MIPS pipeline. Owns the HI/LO registers.
- Accepts one operation per start pulse from the ID/EX datapath.
- Exports busy/start so the hazard unit stalls any ID-stage mult/div/mfhi/mflo/mthi/mtlo while an operation is in flight.
- mfhi/mflo read hi/lo directly in EX.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub/msubu (≥1).
- DIV_CYCLES, 10, busy cycles for div/divu (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  single-cycle request; valid when EX holds an md instruction not being flushed.
- md_op  input  4  operation code (package encoding).
- src_a  input  32  rs value (already forwarded).
- src_b  input  32  rt value (already forwarded).
- busy  output  1  operation in flight.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, counter=0, busy=0, hi=0, lo=0, pending result=0. Reset mid-operation discards the operation; hi/lo read 0.
- State machine has two states, IDLE and BUSY.
- IDLE, start=1 with a multiply/divide op:
  - Compute the 64-bit result from src_a/src_b in that cycle and latch it into pending {ph,pl}.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to BUSY.
- BUSY:
  - busy=1.
  - Counter decrements each cycle.
  - On the edge where counter==1: hi<=ph, lo<=pl, go to IDLE, busy drops the next cycle.
  - busy is high for exactly N cycles, starting the cycle after start.
  - hi/lo keep their old values until the commit edge.
- mthi/mtlo (start=1 in IDLE): hi<=src_a or lo<=src_a on that edge; no busy; the other register is unchanged.
- start while BUSY: ignored. The hazard unit guarantees this never happens; the simulation assertion fires.
- md_op=MD_NONE or an undefined code with start=1: no effect.
- Signed multiply: 64-bit two's-complement product. Unsigned: zero-extended product. {hi,lo} = product.
- Signed divide: lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - Special case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (signed or unsigned): lo=0xFFFFFFFF, hi=src_a.
- Multiply and divide are computed behaviourally in one cycle; the latency is modelled only by the counter.

Optional Feature:
- Macro MD_MADD_EN.
- When defined:
  - MADD/MADDU/MSUB/MSUBU are accepted.
  - Pending = {hi,lo} ± product (signed or unsigned product as named), computed from the hi/lo values at the start cycle.
  - Latency is MULT_CYCLES; wraps mod 2^64.
- When undefined: these codes behave as MD_NONE (no busy, no change).

Decomposition:
- Package md_pkg:
  - md_op encodings: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6, MD_MADD=7, MD_MADDU=8, MD_MSUB=9, MD_MSUBU=10.
  - State encodings for IDLE and BUSY.
- One sub-module, md_divider: combinational signed/unsigned 32-bit divider that handles divide-by-zero and the overflow case. The multiplier stays inline.

Test Plan:
- MULT 0xFFFFFFFF×0x00000002 → busy 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (−7) / 2 → busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 → lo=3, hi=1.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. DIVU 0x1234 / 0 → lo=0xFFFFFFFF, hi=0x1234.
- MTHI 0xDEADBEEF then MTLO 0x00C0FFEE in consecutive cycles → busy never asserts; hi=0xDEADBEEF, lo=0x00C0FFEE after the second edge.
- Start DIV 100/3, assert reset in the 4th busy cycle → busy=0, hi=lo=0 immediately. A following MULT 3×4 completes with lo=12, hi=0.
- MD_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU 1×1 → hi=1, lo=0. Without the macro, the same stimulus leaves hi=0, lo=0xFFFFFFFF and busy=0.
